rob_dur_accum: RTL

- Downstream consumer of the ROB residency-duration monitor.
- Takes the sampled dispatch-to-commit (dp) and writeback-to-commit (fast/slow) durations, one per capture event.
- Accumulates saturating per-class sums, sample counts and maxima over a measurement window; freezes them when the window closes.
- Exposes the results to the AVF collection logic through a 1-cycle-latency read port.

---
 rtl/rob_dur_accum_if.sv | 61 ++++++
 rtl/rob_dur_accum.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_dur_accum_if.sv
// ---------------------------------------------------------------------------
// rob_dur_accum_if
// Bundles the control pulses, duration capture strobes, read port and status
// outputs of rob_dur_accum. The clock and reset stay plain module ports.
//
// Signals:
//   start/stop/clear        window control pulses (driver -> accumulator)
//   dp_valid/dp_dur         dispatch-to-commit duration sample
//   wb_valid/wb_fast/wb_dur writeback-to-commit sample with fast/slow class
//   rd_req/rd_sel/rd_bin    read request, class select, histogram bin index
//   rd_valid/rd_sum/rd_cnt/rd_max  read response, one cycle after rd_req
//   state/done/ovf          window state, close pulse, sticky saturation
//
// Modports:
//   master : the side that drives samples and requests (AVF collector / bench)
//   slave  : the accumulator itself
// ---------------------------------------------------------------------------
interface rob_dur_accum_if #(
  parameter int DUR_W = 10,
  parameter int SUM_W = 24,
  parameter int CNT_W = 14
);

  logic             start;
  logic             stop;
  logic             clear;
  logic             dp_valid;
  logic [DUR_W-1:0] dp_dur;
  logic             wb_valid;
  logic             wb_fast;
  logic [DUR_W-1:0] wb_dur;
  logic             rd_req;
  logic [1:0]       rd_sel;
  logic [2:0]       rd_bin;
  logic             rd_valid;
  logic [SUM_W-1:0] rd_sum;
  logic [CNT_W-1:0] rd_cnt;
  logic [DUR_W-1:0] rd_max;
  logic [1:0]       state;
  logic             done;
  logic             ovf;

  modport master (
    output start, stop, clear,
    output dp_valid, dp_dur,
    output wb_valid, wb_fast, wb_dur,
    output rd_req, rd_sel, rd_bin,
    input  rd_valid, rd_sum, rd_cnt, rd_max,
    input  state, done, ovf
  );

  modport slave (
    input  start, stop, clear,
    input  dp_valid, dp_dur,
    input  wb_valid, wb_fast, wb_dur,
    input  rd_req, rd_sel, rd_bin,
    output rd_valid, rd_sum, rd_cnt, rd_max,
    output state, done, ovf
  );

endinterface

// File: rtl/rob_dur_accum.sv
// ---------------------------------------------------------------------------
// rob_dur_accum
// Downstream consumer of the ROB residency-duration monitor. Accumulates
// saturating sums, sample counts and maxima for three duration classes
// (dispatch-to-commit "dp", writeback fast, writeback slow) over a
// measurement window, freezes them when the window closes and exposes them
// through a one-cycle-latency read port.
//
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset
//   bus      rob_dur_accum_if.slave (control pulses, samples, read port,
//            state/done/ovf status)
//
// Optional feature (macro ROB_DUR_HIST_EN):
//   defined   : eight saturating dp histogram bins indexed by the top three
//               bits of dp_dur, readable with rd_sel = 3 on rd_cnt
//   undefined : no bin storage, rd_sel = 3 reads back all zeros
//
// Window state encoding on bus.state: 0 = IDLE, 1 = ACCUM, 2 = HOLD.
// CNT_W must exceed WINDOW_LOG2 so the dp count cannot saturate before the
// window closes.
// ---------------------------------------------------------------------------
module rob_dur_accum #(
  parameter int DUR_W       = 10,
  parameter int SUM_W       = 24,
  parameter int CNT_W       = 14,
  parameter int WINDOW_LOG2 = 8
) (
  input logic           clk_i,
  input logic           reset_i,
  rob_dur_accum_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DP   = 0;
  localparam int FAST = 1;
  localparam int SLOW = 2;

  localparam logic [SUM_W-1:0] SumMax = '1;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] WinCnt = CNT_W'(2 ** WINDOW_LOG2);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [SUM_W-1:0] sum_q [3];
  logic [SUM_W-1:0] sum_d [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [DUR_W-1:0] max_q [3];
  logic [DUR_W-1:0] max_d [3];

  logic             rdValid_q, rdValid_d;
  logic [SUM_W-1:0] rdSum_q, rdSum_d;
  logic [CNT_W-1:0] rdCnt_q, rdCnt_d;
  logic [DUR_W-1:0] rdMax_q, rdMax_d;

  logic [2:0]       classHit;
  logic [DUR_W-1:0] classDur [3];
  logic [SUM_W:0]   sumWide [3];
  logic [CNT_W:0]   cntWide [3];
  logic             satHit;

`ifdef ROB_DUR_HIST_EN
  logic [CNT_W-1:0] bin_q [8];
  logic [CNT_W-1:0] bin_d [8];
  logic [2:0]       binIdx;
  logic [CNT_W:0]   binWide;
`else
  logic             unusedRdBin;
`endif

  // One extra carry bit on the sum so saturation can be detected as a carry
  // out rather than by comparing against the limit.
  function automatic logic [SUM_W:0] sumAdd(input logic [SUM_W-1:0] a,
                                             input logic [DUR_W-1:0] b);
    sumAdd = {1'b0, a} + {{(SUM_W + 1 - DUR_W){1'b0}}, b};
  endfunction

  function automatic logic [CNT_W:0] cntInc(input logic [CNT_W-1:0] c);
    cntInc = {1'b0, c} + {{CNT_W{1'b0}}, 1'b1};
  endfunction

  // Route each strobe to its class. dp and wb may hit in the same cycle;
  // the writeback sample lands in exactly one of fast/slow.
  assign classHit[DP]   = bus.dp_valid;
  assign classHit[FAST] = bus.wb_valid & bus.wb_fast;
  assign classHit[SLOW] = bus.wb_valid & ~bus.wb_fast;
  assign classDur[DP]   = bus.dp_dur;
  assign classDur[FAST] = bus.wb_dur;
  assign classDur[SLOW] = bus.wb_dur;

`ifdef ROB_DUR_HIST_EN
  assign binIdx  = bus.dp_dur[DUR_W-1 -: 3];
  assign binWide = cntInc(bin_q[binIdx]);
`else
  assign unusedRdBin = ^bus.rd_bin;
`endif

  // Next-state and accumulator update. clear beats start, start beats stop,
  // and samples only count while the window is open. A start inside ACCUM
  // restarts the window, dropping any samples of that cycle. The window
  // closes on stop or on the dp sample that brings the dp count to the
  // window size; that cycle's samples from every class are still counted.
  // The read port snapshots the registered values, so a read sees the state
  // before this edge's updates.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    satHit    = 1'b0;
    rdValid_d = bus.rd_req;
    rdSum_d   = rdSum_q;
    rdCnt_d   = rdCnt_q;
    rdMax_d   = rdMax_q;
    for (int c = 0; c < 3; c++) begin
      sum_d[c]   = sum_q[c];
      cnt_d[c]   = cnt_q[c];
      max_d[c]   = max_q[c];
      sumWide[c] = sumAdd(sum_q[c], classDur[c]);
      cntWide[c] = cntInc(cnt_q[c]);
    end
`ifdef ROB_DUR_HIST_EN
    for (int b = 0; b < 8; b++) begin
      bin_d[b] = bin_q[b];
    end
`endif

    if (bus.clear || bus.start) begin
      state_d = bus.clear ? IDLE : ACCUM;
      ovf_d   = 1'b0;
      for (int c = 0; c < 3; c++) begin
        sum_d[c] = '0;
        cnt_d[c] = '0;
        max_d[c] = '0;
      end
`ifdef ROB_DUR_HIST_EN
      for (int b = 0; b < 8; b++) begin
        bin_d[b] = '0;
      end
`endif
    end else if (state_q == ACCUM) begin
      for (int c = 0; c < 3; c++) begin
        if (classHit[c]) begin
          sum_d[c] = sumWide[c][SUM_W] ? SumMax : sumWide[c][SUM_W-1:0];
          cnt_d[c] = cntWide[c][CNT_W] ? CntMax : cntWide[c][CNT_W-1:0];
          max_d[c] = (classDur[c] > max_q[c]) ? classDur[c] : max_q[c];
          satHit   = satHit | sumWide[c][SUM_W] | cntWide[c][CNT_W];
        end
      end
`ifdef ROB_DUR_HIST_EN
      if (bus.dp_valid) begin
        bin_d[binIdx] = binWide[CNT_W] ? CntMax : binWide[CNT_W-1:0];
        satHit        = satHit | binWide[CNT_W];
      end
`endif
      ovf_d = ovf_q | satHit;
      if (bus.stop || (classHit[DP] && (cntWide[DP][CNT_W-1:0] == WinCnt))) begin
        state_d = HOLD;
        done_d  = 1'b1;
      end
    end

    if (bus.rd_req) begin
      case (bus.rd_sel)
        2'd0: begin
          rdSum_d = sum_q[DP];
          rdCnt_d = cnt_q[DP];
          rdMax_d = max_q[DP];
        end
        2'd1: begin
          rdSum_d = sum_q[FAST];
          rdCnt_d = cnt_q[FAST];
          rdMax_d = max_q[FAST];
        end
        2'd2: begin
          rdSum_d = sum_q[SLOW];
          rdCnt_d = cnt_q[SLOW];
          rdMax_d = max_q[SLOW];
        end
        default: begin
          rdSum_d = '0;
          rdMax_d = '0;
`ifdef ROB_DUR_HIST_EN
          rdCnt_d = bin_q[bus.rd_bin];
`else
          rdCnt_d = '0;
`endif
        end
      endcase
    end
  end

  // State, accumulator and read-port registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rdValid_q <= 1'b0;
      rdSum_q   <= '0;
      rdCnt_q   <= '0;
      rdMax_q   <= '0;
      for (int c = 0; c < 3; c++) begin
        sum_q[c] <= '0;
        cnt_q[c] <= '0;
        max_q[c] <= '0;
      end
`ifdef ROB_DUR_HIST_EN
      for (int b = 0; b < 8; b++) begin
        bin_q[b] <= '0;
      end
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      rdValid_q <= rdValid_d;
      rdSum_q   <= rdSum_d;
      rdCnt_q   <= rdCnt_d;
      rdMax_q   <= rdMax_d;
      for (int c = 0; c < 3; c++) begin
        sum_q[c] <= sum_d[c];
        cnt_q[c] <= cnt_d[c];
        max_q[c] <= max_d[c];
      end
`ifdef ROB_DUR_HIST_EN
      for (int b = 0; b < 8; b++) begin
        bin_q[b] <= bin_d[b];
      end
`endif
    end
  end

  assign bus.state    = state_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;
  assign bus.rd_valid = rdValid_q;
  assign bus.rd_sum   = rdSum_q;
  assign bus.rd_cnt   = rdCnt_q;
  assign bus.rd_max   = rdMax_q;

endmodule
